// File: rtl/vrf_pkg.sv
// Shared defaults, clear-FSM state encoding and lane/vector types for the vector register file.
`timescale 1ns/1ps
package vrf_pkg;

    localparam int VRF_DATA_WIDTH  = 8;
    localparam int VRF_VECTOR_SIZE = 8;
    localparam int VRF_REGNUM      = 16;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    typedef logic [VRF_DATA_WIDTH-1:0] lane_t;
    typedef lane_t [VRF_VECTOR_SIZE-1:0] vec_t;

endpackage

// File: rtl/vrf_scoreboard.sv
// Pending-write scoreboard: one busy bit per vector register, set on allocate,
// cleared by an accepted write or by the bulk-clear sweep.
`timescale 1ns/1ps
module vrf_scoreboard #(
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = $clog2(REGNUM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_en,
    input  logic [ADDRESSWIDTH-1:0] set_addr,
    input  logic                    clr_en,
    input  logic [ADDRESSWIDTH-1:0] clr_addr,
    input  logic                    wipe_en,
    input  logic [ADDRESSWIDTH-1:0] wipe_addr,
    input  logic [ADDRESSWIDTH-1:0] ra1,
    input  logic [ADDRESSWIDTH-1:0] ra2,
    output logic                    busy1,
    output logic                    busy2
);

    localparam logic [ADDRESSWIDTH:0] LIMIT = (ADDRESSWIDTH+1)'(REGNUM);

    logic [REGNUM-1:0] busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (clr_en)
                busy[clr_addr] <= 1'b0;
            // NOTE: the last non-blocking assignment to a bit wins, so ordering the set after the clear gives set priority.
            if (set_en)
                busy[set_addr] <= 1'b1;
            if (wipe_en)
                busy[wipe_addr] <= 1'b0;
        end
    end

    assign busy1 = ({1'b0, ra1} < LIMIT) ? busy[ra1] : 1'b0;
    assign busy2 = ({1'b0, ra2} < LIMIT) ? busy[ra2] : 1'b0;

endmodule

// File: rtl/vec_reg_bank.sv
// Vector register file: lane-masked writes, two combinational read ports, busy scoreboard, bulk clear.
// Optional macro VRF_BYPASS_EN forwards same-cycle write data onto matching read ports.
`timescale 1ns/1ps
module vec_reg_bank
    import vrf_pkg::*;
#(
    parameter int DATA_WIDTH   = VRF_DATA_WIDTH,
    parameter int VECTOR_SIZE  = VRF_VECTOR_SIZE,
    parameter int REGNUM       = VRF_REGNUM,
    parameter int ADDRESSWIDTH = $clog2(REGNUM)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [ADDRESSWIDTH-1:0]           wa,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] wd,
    input  logic [VECTOR_SIZE-1:0]            wmask,
    input  logic [ADDRESSWIDTH-1:0]           ra1,
    input  logic [ADDRESSWIDTH-1:0]           ra2,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] rd1,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] rd2,
    input  logic                              alloc_valid,
    input  logic [ADDRESSWIDTH-1:0]           alloc_addr,
    output logic                              busy1,
    output logic                              busy2,
    input  logic                              clr_start,
    output logic                              clr_busy,
    output logic                              clr_done
);

    localparam int VW = VECTOR_SIZE * DATA_WIDTH;
    localparam logic [ADDRESSWIDTH:0]   LIMIT = (ADDRESSWIDTH+1)'(REGNUM);
    localparam logic [ADDRESSWIDTH-1:0] LAST  = ADDRESSWIDTH'(REGNUM - 1);

    clr_state_t              state;
    logic [ADDRESSWIDTH-1:0] cnt;
    logic [VW-1:0]           mem [REGNUM];

    logic wa_ok, alloc_ok, ra1_ok, ra2_ok;
    logic wr_en, alloc_en;

    // Addresses past REGNUM exist only when REGNUM is not a power of two.
    assign wa_ok    = ({1'b0, wa} < LIMIT);
    assign alloc_ok = ({1'b0, alloc_addr} < LIMIT);
    assign ra1_ok   = ({1'b0, ra1} < LIMIT);
    assign ra2_ok   = ({1'b0, ra2} < LIMIT);

    assign clr_busy = (state == CLEAR);
    assign wr_en    = we && !clr_busy && wa_ok;
    assign alloc_en = alloc_valid && !clr_busy && alloc_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage is flops, not a RAM macro, because reset must zero every register immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REGNUM; r++)
                mem[r] <= '0;
        end else if (clr_busy) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < VECTOR_SIZE; l++)
                if (wmask[l])
                    mem[wa][l*DATA_WIDTH +: DATA_WIDTH] <= wd[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef VRF_BYPASS_EN
    function automatic logic [VW-1:0] forward(input logic [VW-1:0] stored, input logic hit);
        forward = stored;
        if (hit)
            for (int l = 0; l < VECTOR_SIZE; l++)
                if (wmask[l])
                    forward[l*DATA_WIDTH +: DATA_WIDTH] = wd[l*DATA_WIDTH +: DATA_WIDTH];
    endfunction
`endif

    // NOTE: every output of a combinational block gets a value on every path first, so no latch is inferred.
    always_comb begin
        rd1 = ra1_ok ? mem[ra1] : '0;
        rd2 = ra2_ok ? mem[ra2] : '0;
`ifdef VRF_BYPASS_EN
        rd1 = forward(rd1, wr_en && (ra1 == wa));
        rd2 = forward(rd2, wr_en && (ra2 == wa));
`endif
    end

    vrf_scoreboard #(
        .REGNUM       (REGNUM),
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (alloc_en),
        .set_addr  (alloc_addr),
        .clr_en    (wr_en),
        .clr_addr  (wa),
        .wipe_en   (clr_busy),
        .wipe_addr (cnt),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

endmodule

// File: tb/tb_vec_reg_bank.sv
// Bench for vec_reg_bank: a 16-register and a 12-register instance driven with directed and random
// stimulus; expectations from a lane/array model are queued and compared by a negedge monitor.
`timescale 1ns/1ps
module tb_vec_reg_bank;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [63:0] wd;
        logic [7:0]  wmask;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        alloc;
        logic [3:0]  aa;
        logic        clr;
    } stim_t;

    typedef logic [95:0] tag_t;

    typedef struct {
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic        b1;
        logic        b2;
        logic        cb;
        logic        cd;
        tag_t        tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we [2];
    logic [3:0]  wa [2];
    logic [63:0] wd [2];
    logic [7:0]  wmask [2];
    logic [3:0]  ra1 [2];
    logic [3:0]  ra2 [2];
    logic [63:0] rd1 [2];
    logic [63:0] rd2 [2];
    logic        alloc_valid [2];
    logic [3:0]  alloc_addr [2];
    logic        busy1 [2];
    logic        busy2 [2];
    logic        clr_start [2];
    logic        clr_busy [2];
    logic        clr_done [2];

    int   checks = 0;
    int   errors = 0;
    tag_t phase = "reset";

    exp_t  q0 [$];
    exp_t  q1 [$];
    stim_t cur [2];

    // Reference model: byte lanes per register, busy flags, and the cycle at which a clear sweep begins.
    logic [7:0] m_mem [2][16][8];
    bit         m_busy [2][16];
    int         clr_s [2];
    int         cyc = 0;

    always #5 clk = ~clk;

    vec_reg_bank #(.DATA_WIDTH(8), .VECTOR_SIZE(8), .REGNUM(16), .ADDRESSWIDTH(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .we(we[0]), .wa(wa[0]), .wd(wd[0]), .wmask(wmask[0]),
        .ra1(ra1[0]), .ra2(ra2[0]), .rd1(rd1[0]), .rd2(rd2[0]),
        .alloc_valid(alloc_valid[0]), .alloc_addr(alloc_addr[0]), .busy1(busy1[0]), .busy2(busy2[0]),
        .clr_start(clr_start[0]), .clr_busy(clr_busy[0]), .clr_done(clr_done[0])
    );

    vec_reg_bank #(.DATA_WIDTH(8), .VECTOR_SIZE(8), .REGNUM(12), .ADDRESSWIDTH(4)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .we(we[1]), .wa(wa[1]), .wd(wd[1]), .wmask(wmask[1]),
        .ra1(ra1[1]), .ra2(ra2[1]), .rd1(rd1[1]), .rd2(rd2[1]),
        .alloc_valid(alloc_valid[1]), .alloc_addr(alloc_addr[1]), .busy1(busy1[1]), .busy2(busy2[1]),
        .clr_start(clr_start[1]), .clr_busy(clr_busy[1]), .clr_done(clr_done[1])
    );

    function automatic int nreg(input int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic bit clearing(input int d);
        return (cyc >= clr_s[d]) && (cyc < clr_s[d] + nreg(d));
    endfunction

    function automatic logic [63:0] read_model(input int d, input logic [3:0] ra, input stim_t s);
        logic [63:0] v;
        v = '0;
        if (int'(ra) < nreg(d)) begin
            for (int l = 0; l < 8; l++)
                v[l*8 +: 8] = m_mem[d][ra][l];
`ifdef VRF_BYPASS_EN
            if (s.we && !clearing(d) && s.wa == ra)
                for (int l = 0; l < 8; l++)
                    if (s.wmask[l])
                        v[l*8 +: 8] = s.wd[l*8 +: 8];
`endif
        end
        return v;
    endfunction

    function automatic bit busy_model(input int d, input logic [3:0] ra);
        return (int'(ra) < nreg(d)) ? m_busy[d][ra] : 1'b0;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 16; r++) begin
                m_busy[d][r] = 1'b0;
                for (int l = 0; l < 8; l++)
                    m_mem[d][r][l] = 8'h00;
            end
            clr_s[d] = -1000;
        end
    endfunction

    function automatic void model_edge(input int d, input stim_t s);
        if (clearing(d)) begin
            for (int l = 0; l < 8; l++)
                m_mem[d][cyc - clr_s[d]][l] = 8'h00;
            m_busy[d][cyc - clr_s[d]] = 1'b0;
        end else begin
            if (s.we && int'(s.wa) < nreg(d)) begin
                for (int l = 0; l < 8; l++)
                    if (s.wmask[l])
                        m_mem[d][s.wa][l] = s.wd[l*8 +: 8];
                m_busy[d][s.wa] = 1'b0;
            end
            if (s.alloc && int'(s.aa) < nreg(d))
                m_busy[d][s.aa] = 1'b1;
            if (s.clr)
                clr_s[d] = cyc + 1;
        end
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.we = 1'b0; s.wa = '0; s.wd = '0; s.wmask = '0;
        s.ra1 = '0; s.ra2 = '0; s.alloc = 1'b0; s.aa = '0; s.clr = 1'b0;
        return s;
    endfunction

    function automatic stim_t rand_stim(input int clr_odds);
        stim_t s;
        s.we    = ($urandom_range(0, 1) == 1);
        s.wa    = 4'($urandom_range(0, 15));
        s.wd    = {$urandom, $urandom};
        s.wmask = 8'($urandom);
        s.ra1   = 4'($urandom_range(0, 15));
        s.ra2   = 4'($urandom_range(0, 15));
        s.alloc = ($urandom_range(0, 2) == 0);
        s.aa    = 4'($urandom_range(0, 15));
        s.clr   = ($urandom_range(0, clr_odds) == 0);
        return s;
    endfunction

    task automatic apply(input int d);
        we[d]          = cur[d].we;
        wa[d]          = cur[d].wa;
        wd[d]          = cur[d].wd;
        wmask[d]       = cur[d].wmask;
        ra1[d]         = cur[d].ra1;
        ra2[d]         = cur[d].ra2;
        alloc_valid[d] = cur[d].alloc;
        alloc_addr[d]  = cur[d].aa;
        clr_start[d]   = cur[d].clr;
    endtask

    // One clock cycle: drive, queue the expected outputs, advance the model at the edge.
    task automatic step(input bit rv);
        exp_t e;
        rst_n = rv;
        if (!rv)
            model_reset();
        for (int d = 0; d < 2; d++) begin
            apply(d);
            e.rd1 = read_model(d, cur[d].ra1, cur[d]);
            e.rd2 = read_model(d, cur[d].ra2, cur[d]);
            e.b1  = busy_model(d, cur[d].ra1);
            e.b2  = busy_model(d, cur[d].ra2);
            e.cb  = clearing(d);
            e.cd  = (cyc == clr_s[d] + nreg(d));
            e.tag = phase;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        if (rv)
            for (int d = 0; d < 2; d++)
                model_edge(d, cur[d]);
        cyc++;
        #1;
    endtask

    task automatic check(input int d, input tag_t tag, input string what, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %0s dut%0d %0s: got %h expected %h (t=%0t)", tag, d, what, got, want, $time);
        end
    endtask

    task automatic compare(input int d, input exp_t e);
        check(d, e.tag, "rd1", rd1[d], e.rd1);
        check(d, e.tag, "rd2", rd2[d], e.rd2);
        check(d, e.tag, "busy1", 64'(busy1[d]), 64'(e.b1));
        check(d, e.tag, "busy2", 64'(busy2[d]), 64'(e.b2));
        check(d, e.tag, "clr_busy", 64'(clr_busy[d]), 64'(e.cb));
        check(d, e.tag, "clr_done", 64'(clr_done[d]), 64'(e.cd));
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) compare(0, q0.pop_front());
        if (q1.size() > 0) compare(1, q1.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        model_reset();
        cur[0] = idle_stim();
        cur[1] = idle_stim();
        apply(0);
        apply(1);
        @(posedge clk);
        #1;

        phase = "reset";
        cur[0].ra1 = 4'd3; cur[0].ra2 = 4'd15;
        step(1'b0);
        step(1'b0);

        phase = "masked";
        cur[0] = idle_stim();
        cur[0].we = 1'b1; cur[0].wa = 4'd3; cur[0].wd = 64'h0807060504030201; cur[0].wmask = 8'h0F;
        cur[0].ra1 = 4'd3; cur[0].ra2 = 4'd3;
        step(1'b1);
        cur[0] = idle_stim(); cur[0].ra1 = 4'd3;
        step(1'b1);

        phase = "bypass";
        cur[0] = idle_stim();
        cur[0].we = 1'b1; cur[0].wa = 4'd5; cur[0].wd = 64'hAAAAAAAAAAAAAAAA; cur[0].wmask = 8'hFF;
        cur[0].ra2 = 4'd5; cur[0].ra1 = 4'd3;
        step(1'b1);
        cur[0] = idle_stim(); cur[0].ra2 = 4'd5;
        step(1'b1);

        phase = "scoreboard";
        cur[0] = idle_stim(); cur[0].alloc = 1'b1; cur[0].aa = 4'd7; cur[0].ra1 = 4'd7;
        step(1'b1);
        cur[0] = idle_stim(); cur[0].ra1 = 4'd7;
        step(1'b1);
        cur[0].we = 1'b1; cur[0].wa = 4'd7; cur[0].wd = 64'h1111; cur[0].wmask = 8'h01;
        step(1'b1);
        cur[0] = idle_stim(); cur[0].ra1 = 4'd7;
        step(1'b1);
        cur[0].we = 1'b1; cur[0].wa = 4'd7; cur[0].wmask = 8'hFF; cur[0].wd = 64'h77;
        cur[0].alloc = 1'b1; cur[0].aa = 4'd7;
        step(1'b1);
        cur[0] = idle_stim(); cur[0].ra1 = 4'd7;
        step(1'b1);

        for (int pass = 0; pass < 2; pass++) begin
            phase = (pass == 0) ? "clear_fill" : "rstmid_fill";
            for (int r = 0; r < 16; r++) begin
                cur[0] = idle_stim();
                cur[0].we = 1'b1; cur[0].wa = 4'(r); cur[0].wd = {$urandom, $urandom} | 64'h1;
                cur[0].wmask = 8'hFF; cur[0].alloc = 1'b1; cur[0].aa = 4'(15 - r);
                cur[0].ra1 = 4'(r); cur[0].ra2 = 4'($urandom_range(0, 15));
                step(1'b1);
            end
            phase = (pass == 0) ? "clear" : "rst_mid";
            cur[0] = idle_stim(); cur[0].clr = 1'b1; cur[0].ra1 = 4'd0; cur[0].ra2 = 4'd15;
            step(1'b1);
            if (pass == 0) begin
                for (int k = 0; k < 16; k++) begin
                    cur[0] = rand_stim(1);
                    step(1'b1);
                end
                phase = "clear_after";
                for (int k = 0; k < 8; k++) begin
                    cur[0] = idle_stim(); cur[0].ra1 = 4'(2 * k); cur[0].ra2 = 4'(2 * k + 1);
                    step(1'b1);
                end
            end else begin
                for (int k = 0; k < 5; k++) begin
                    cur[0] = idle_stim(); cur[0].ra1 = 4'd15; cur[0].ra2 = 4'(k);
                    step(1'b1);
                end
                cur[0] = idle_stim(); cur[0].ra1 = 4'd15; cur[0].ra2 = 4'd10;
                step(1'b0);
                step(1'b0);
                phase = "rst_release";
                for (int k = 0; k < 20; k++) begin
                    cur[0] = idle_stim(); cur[0].ra1 = 4'(k % 16); cur[0].ra2 = 4'd15;
                    step(1'b1);
                end
            end
        end

        phase = "regnum12";
        cur[0] = idle_stim();
        cur[1] = idle_stim();
        cur[1].we = 1'b1; cur[1].wa = 4'd1; cur[1].wd = 64'hDEADBEEFCAFEF00D; cur[1].wmask = 8'hFF;
        step(1'b1);
        cur[1] = idle_stim();
        cur[1].we = 1'b1; cur[1].wa = 4'd13; cur[1].wd = 64'h5555555555555555; cur[1].wmask = 8'hFF;
        cur[1].ra1 = 4'd13; cur[1].ra2 = 4'd1;
        step(1'b1);
        cur[1] = idle_stim(); cur[1].ra1 = 4'd13; cur[1].ra2 = 4'd1;
        cur[1].alloc = 1'b1; cur[1].aa = 4'd13;
        step(1'b1);
        cur[1] = idle_stim(); cur[1].ra1 = 4'd13; cur[1].ra2 = 4'd12;
        step(1'b1);
        for (int r = 0; r < 12; r += 2) begin
            cur[1] = idle_stim(); cur[1].ra1 = 4'(r); cur[1].ra2 = 4'(r + 1);
            step(1'b1);
        end

        phase = "random";
        for (int k = 0; k < 400; k++) begin
            cur[0] = rand_stim(40);
            cur[1] = rand_stim(40);
            step(1'b1);
        end

        cur[0] = idle_stim();
        cur[1] = idle_stim();
        apply(0);
        apply(1);
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checks++;
        if (q0.size() > 0 || q1.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", q0.size() + q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
